id_ex_stage: RTL and testbench

ID/EX pipeline stage of the 5-stage MIPS core, directly upstream of the execute-stage `ALU`. It registers decoded operands and controls at the end of ID and resolves EX/MEM and MEM/WB forwarding to drive the ALU's `A`, `B`, `sel` and `Shamt` inputs. It also detects load-use hazards, stalls IF/ID, inserts bubbles, and honours branch flushes.

---
 rtl/mips_pkg.sv | 38 +++
 rtl/id_ex_stage_forward_unit.sv | 34 +++
 rtl/id_ex_stage.sv | 209 ++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the 5-stage MIPS core datapath.
//   REG_ZERO      : index of the hard-wired zero register (never forwarded)
//   ALU_*         : ALU opcode encodings driven on alu_sel
//   fwd_sel_e     : operand source select produced by forward_unit
//   id_ex_ctrl_t  : control bundle carried by the ID/EX pipeline register
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,  // registered ID/EX value
    FWD_MWB = 2'b01,  // writeback data of the instruction in WB
    FWD_EXM = 2'b10   // ALU result of the instruction in MEM
  } fwd_sel_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [3:0] alu_sel;
  } id_ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// -----------------------------------------------------------------------------
// forward_unit
// Combinational operand-source select for one EX source register.
// The younger producer (in MEM) wins over the older one (in WB); register 0
// is never forwarded because its value is architecturally constant.
// Ports:
//   src_i           : source register index of the instruction in EX
//   exm_reg_write_i : write enable of the instruction in MEM
//   exm_rd_i        : destination of the instruction in MEM
//   mwb_reg_write_i : write enable of the instruction in WB
//   mwb_rd_i        : destination of the instruction in WB
//   sel_o           : FWD_EXM / FWD_MWB / FWD_REG
// -----------------------------------------------------------------------------
module forward_unit
  import mips_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic       exm_reg_write_i,
  input  logic [4:0] exm_rd_i,
  input  logic       mwb_reg_write_i,
  input  logic [4:0] mwb_rd_i,
  output fwd_sel_e   sel_o
);

  always_comb begin
    sel_o = FWD_REG;
    if (exm_reg_write_i && (exm_rd_i != REG_ZERO) && (exm_rd_i == src_i)) begin
      sel_o = FWD_EXM;
    end else if (mwb_reg_write_i && (mwb_rd_i != REG_ZERO) && (mwb_rd_i == src_i)) begin
      sel_o = FWD_MWB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the 5-stage MIPS core. Registers decoded operands
// and controls at the end of ID, resolves operand bypassing for the EX ALU,
// detects data hazards that need a stall, inserts bubbles and honours flushes.
//
// Build option:
//   ID_EX_FORWARDING_EN defined   : MEM/WB bypass muxes; stall only on load-use.
//   ID_EX_FORWARDING_EN undefined : no bypass; ID stalls while any producer of a
//                                   nonzero source is still in EX or MEM.
//
// Ports:
//   clk, rst                      : rising-edge clock, sync active-high reset
//   id_*                          : decoded instruction currently in ID
//   flush                         : kill the instruction entering EX
//   exm_reg_write/exm_rd/exm_result : producer in MEM
//   mwb_reg_write/mwb_rd/mwb_result : producer in WB
//   stall                         : hold PC and IF/ID (combinational)
//   ex_valid                      : EX holds a real instruction
//   alu_a, alu_b, alu_sel, alu_shamt : ALU inputs
//   ex_store_data                 : bypassed rt value for stores
//   ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg : EX controls
// -----------------------------------------------------------------------------
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         id_valid,
  input  logic [n-1:0] id_rs_data,
  input  logic [n-1:0] id_rt_data,
  input  logic [4:0]   id_rs,
  input  logic [4:0]   id_rt,
  input  logic [4:0]   id_rd,
  input  logic [n-1:0] id_imm,
  input  logic [4:0]   id_shamt,
  input  logic [3:0]   id_alu_sel,
  input  logic         id_alu_src,
  input  logic         id_reg_write,
  input  logic         id_mem_read,
  input  logic         id_mem_write,
  input  logic         id_mem_to_reg,
  input  logic         flush,
  input  logic         exm_reg_write,
  input  logic [4:0]   exm_rd,
  input  logic [n-1:0] exm_result,
  input  logic         mwb_reg_write,
  input  logic [4:0]   mwb_rd,
  input  logic [n-1:0] mwb_result,
  output logic         stall,
  output logic         ex_valid,
  output logic [n-1:0] alu_a,
  output logic [n-1:0] alu_b,
  output logic [3:0]   alu_sel,
  output logic [4:0]   alu_shamt,
  output logic [n-1:0] ex_store_data,
  output logic [4:0]   ex_rd,
  output logic         ex_reg_write,
  output logic         ex_mem_read,
  output logic         ex_mem_write,
  output logic         ex_mem_to_reg
);

  logic         valid_q,   valid_d;
  id_ex_ctrl_t  ctrl_q,    ctrl_d;
  logic [n-1:0] rs_data_q, rs_data_d;
  logic [n-1:0] rt_data_q, rt_data_d;
  logic [n-1:0] imm_q,     imm_d;
  logic [4:0]   rs_q,      rs_d;
  logic [4:0]   rt_q,      rt_d;
  logic [4:0]   rd_q,      rd_d;
  logic [4:0]   shamt_q,   shamt_d;

  logic [n-1:0] rs_fwd;
  logic [n-1:0] rt_fwd;

  // Next-state: flush and stall both load a bubble (all fields cleared).
  always_comb begin
    valid_d   = 1'b0;
    ctrl_d    = '0;
    rs_data_d = '0;
    rt_data_d = '0;
    imm_d     = '0;
    rs_d      = '0;
    rt_d      = '0;
    rd_d      = '0;
    shamt_d   = '0;
    if (!flush && !stall) begin
      valid_d            = id_valid;
      ctrl_d.reg_write   = id_reg_write;
      ctrl_d.mem_read    = id_mem_read;
      ctrl_d.mem_write   = id_mem_write;
      ctrl_d.mem_to_reg  = id_mem_to_reg;
      ctrl_d.alu_src     = id_alu_src;
      ctrl_d.alu_sel     = id_alu_sel;
      rs_data_d          = id_rs_data;
      rt_data_d          = id_rt_data;
      imm_d              = id_imm;
      rs_d               = id_rs;
      rt_d               = id_rt;
      rd_d               = id_rd;
      shamt_d            = id_shamt;
    end
  end

  // ID -> EX register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      shamt_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      shamt_q   <= shamt_d;
    end
  end

`ifdef ID_EX_FORWARDING_EN
  fwd_sel_e rs_sel;
  fwd_sel_e rt_sel;

  forward_unit u_fwd_rs (
    .src_i           (rs_q),
    .exm_reg_write_i (exm_reg_write),
    .exm_rd_i        (exm_rd),
    .mwb_reg_write_i (mwb_reg_write),
    .mwb_rd_i        (mwb_rd),
    .sel_o           (rs_sel)
  );

  forward_unit u_fwd_rt (
    .src_i           (rt_q),
    .exm_reg_write_i (exm_reg_write),
    .exm_rd_i        (exm_rd),
    .mwb_reg_write_i (mwb_reg_write),
    .mwb_rd_i        (mwb_rd),
    .sel_o           (rt_sel)
  );

  always_comb begin
    rs_fwd = rs_data_q;
    case (rs_sel)
      FWD_EXM: rs_fwd = exm_result;
      FWD_MWB: rs_fwd = mwb_result;
      default: rs_fwd = rs_data_q;
    endcase
  end

  always_comb begin
    rt_fwd = rt_data_q;
    case (rt_sel)
      FWD_EXM: rt_fwd = exm_result;
      FWD_MWB: rt_fwd = mwb_result;
      default: rt_fwd = rt_data_q;
    endcase
  end

  // Only a load in EX cannot be bypassed in time: its data exists after MEM.
  assign stall = id_valid && valid_q && ctrl_q.mem_read && (rd_q != REG_ZERO) &&
                 ((rd_q == id_rs) || (rd_q == id_rt));
`else
  logic ex_wr_valid;
  logic rs_hit;
  logic rt_hit;
  logic unused_nofwd;

  assign rs_fwd = rs_data_q;
  assign rt_fwd = rt_data_q;

  // Without bypass, ID waits until every pending producer has reached WB,
  // where the write-through register file supplies the value directly.
  assign ex_wr_valid = valid_q && ctrl_q.reg_write;
  assign rs_hit = (id_rs != REG_ZERO) &&
                  ((ex_wr_valid && (rd_q == id_rs)) || (exm_reg_write && (exm_rd == id_rs)));
  assign rt_hit = (id_rt != REG_ZERO) &&
                  ((ex_wr_valid && (rd_q == id_rt)) || (exm_reg_write && (exm_rd == id_rt)));
  assign stall  = id_valid && (rs_hit || rt_hit);

  assign unused_nofwd = ^{exm_result, mwb_reg_write, mwb_rd, mwb_result, rs_q, rt_q};
`endif

  assign ex_valid      = valid_q;
  assign alu_a         = rs_fwd;
  assign alu_b         = ctrl_q.alu_src ? imm_q : rt_fwd;
  assign alu_sel       = ctrl_q.alu_sel;
  assign alu_shamt     = shamt_q;
  assign ex_store_data = rt_fwd;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Scoreboard bench for id_ex_stage. Each cycle the expected ID/EX register
// content is pushed when ID is driven and popped one cycle later, where the
// expected ALU operands are derived with the bypass inputs present at that
// time. A small write-through register file and an optional MEM/WB shift
// model supply realistic upstream/downstream stimulus.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;
  import mips_pkg::*;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [3:0]  id_alu_sel;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        flush;
  logic        exm_reg_write, mwb_reg_write;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_result, mwb_result;
  logic        stall, ex_valid;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_sel;
  logic [4:0]  alu_shamt, ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  id_ex_stage #(.n(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_alu_sel(id_alu_sel), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .flush(flush),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .stall(stall), .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .alu_shamt(alu_shamt), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        v, rw, mr, mw, m2r, src;
    logic [3:0]  sel;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] a, b, imm;
  } ex_t;

  ex_t         sb_q[$];
  ex_t         mdl;
  logic [31:0] rf[32];
  logic        auto_pipe;
  logic        exp_stall, dut_stall;
  int          n_cmp, n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rf_rd(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (mwb_reg_write && (mwb_rd == r)) return mwb_result;
    return rf[r];
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] regv);
`ifdef ID_EX_FORWARDING_EN
    if (exm_reg_write && (exm_rd != 5'd0) && (exm_rd == r)) return exm_result;
    if (mwb_reg_write && (mwb_rd != 5'd0) && (mwb_rd == r)) return mwb_result;
`endif
    return regv;
  endfunction

  function automatic logic hit(input logic [4:0] r);
    return (r != 5'd0) && ((mdl.v && mdl.rw && (mdl.rd == r)) ||
                           (exm_reg_write && (exm_rd == r)));
  endfunction

  function automatic logic model_stall();
`ifdef ID_EX_FORWARDING_EN
    return id_valid && mdl.v && mdl.mr && (mdl.rd != 5'd0) &&
           ((mdl.rd == id_rs) || (mdl.rd == id_rt));
`else
    return id_valid && (hit(id_rs) || hit(id_rt));
`endif
  endfunction

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] imm, input logic src,
                        input logic [3:0] sel, input logic rw, input logic mr,
                        input logic mw, input logic m2r);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_imm = imm;
    id_alu_src = src; id_alu_sel = sel; id_shamt = rs ^ rd;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, ALU_AND, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock: check current outputs against the popped expectation, push
  // the expected next register content, advance the clock and downstream model.
  task automatic cycle();
    ex_t e;
    ex_t nx;
    id_rs_data = rf_rd(id_rs);
    id_rt_data = rf_rd(id_rt);
    #1;
    exp_stall = model_stall();
    dut_stall = stall;
    chk("stall", stall, exp_stall);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("ex_valid", ex_valid, e.v);
      chk("alu_a", alu_a, fwd(e.rs, e.a));
      chk("alu_b", alu_b, e.src ? e.imm : fwd(e.rt, e.b));
      chk("store_data", ex_store_data, fwd(e.rt, e.b));
      chk("alu_sel", alu_sel, e.sel);
      chk("alu_shamt", alu_shamt, e.shamt);
      chk("ex_rd", ex_rd, e.rd);
      chk("ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
          {e.rw, e.mr, e.mw, e.m2r});
    end
    nx = '0;
    if (!rst && !flush && !exp_stall) begin
      nx.v = id_valid; nx.rw = id_reg_write; nx.mr = id_mem_read;
      nx.mw = id_mem_write; nx.m2r = id_mem_to_reg; nx.src = id_alu_src;
      nx.sel = id_alu_sel; nx.rs = id_rs; nx.rt = id_rt; nx.rd = id_rd;
      nx.shamt = id_shamt; nx.a = id_rs_data; nx.b = id_rt_data; nx.imm = id_imm;
    end
    sb_q.push_back(nx);
    @(posedge clk);
    #1;
    if (mwb_reg_write && (mwb_rd != 5'd0)) rf[mwb_rd] = mwb_result;
    if (auto_pipe) begin
      mwb_reg_write = exm_reg_write; mwb_rd = exm_rd; mwb_result = exm_result;
      exm_reg_write = mdl.v && mdl.rw; exm_rd = mdl.rd;
      exm_result    = 32'h1000 + {27'd0, mdl.rd};
    end
    mdl = nx;
  endtask

  // Keep the ID instruction in place until it enters EX (bounded).
  task automatic hold_until_accepted(input string tag, output int stalls);
    logic acc;
    acc = 1'b0;
    stalls = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (dut_stall) begin
        stalls++;
        if (stalls == 1) chk({tag, "_bubble"}, ex_valid, 1'b0);
      end
      if (!exp_stall) begin
        acc = 1'b1;
        break;
      end
    end
    chk({tag, "_accept"}, acc, 1'b1);
  endtask

  int st;

  initial begin
    n_cmp = 0; n_bad = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[1] = 32'd5; rf[2] = 32'd7;
    mdl = '0; auto_pipe = 1'b1;
    rst = 1'b1; flush = 1'b0;
    exm_reg_write = 1'b0; exm_rd = 5'd0; exm_result = 32'd0;
    mwb_reg_write = 1'b0; mwb_rd = 5'd0; mwb_result = 32'd0;
    nop();
    cycle();
    cycle();
    rst = 1'b0;

    // add $3,$1,$2 with no hazards
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    nop();
    #1;
    chk("add_a", alu_a, 32'd5);
    chk("add_b", alu_b, 32'd7);
    chk("add_valid", ex_valid, 1'b1);

    // sub $8,$1,$2 then conflicting MEM and WB producers of $1
    set_id(1'b1, 5'd1, 5'd2, 5'd8, 32'd0, 1'b0, ALU_SUB, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    auto_pipe = 1'b0;
    nop();
    exm_reg_write = 1'b1; exm_rd = 5'd1; exm_result = 32'hAA;
    mwb_reg_write = 1'b1; mwb_rd = 5'd1; mwb_result = 32'hBB;
    #1;
`ifdef ID_EX_FORWARDING_EN
    chk("fwd_prio", alu_a, 32'hAA);
`else
    chk("fwd_prio", alu_a, 32'd5);
`endif

    // rs = $0 must never take a bypass, even from a WB write to $0
    exm_reg_write = 1'b0;
    set_id(1'b1, 5'd0, 5'd2, 5'd9, 32'd0, 1'b0, ALU_OR, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    nop();
    mwb_reg_write = 1'b1; mwb_rd = 5'd0; mwb_result = 32'hFF;
    #1;
    chk("r0_nofwd", alu_a, 32'd0);
    cycle();
    auto_pipe = 1'b1;

    // store with immediate offset: alu_b = imm, store data = rt
    set_id(1'b1, 5'd0, 5'd2, 5'd0, 32'h44, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    nop();
    #1;
    chk("imm_b", alu_b, 32'h44);
    chk("store", ex_store_data, 32'd7);
    chk("sw_ctrl", ex_mem_write, 1'b1);
    cycle(); cycle(); cycle();

    // lw $4 followed by add $5,$4,$2
    set_id(1'b1, 5'd0, 5'd0, 5'd4, 32'h10, 1'b1, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle();
    set_id(1'b1, 5'd4, 5'd2, 5'd5, 32'd0, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    hold_until_accepted("lu", st);
`ifdef ID_EX_FORWARDING_EN
    chk("lu_stalls", st, 1);
`else
    chk("lu_stalls", st, 2);
`endif
    nop();
    #1;
    chk("lu_a", alu_a, 32'h1004);
    cycle(); cycle(); cycle();

    // back-to-back dependent adds: add $6,$1,$2 ; add $7,$6,$2
    set_id(1'b1, 5'd1, 5'd2, 5'd6, 32'd0, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    set_id(1'b1, 5'd6, 5'd2, 5'd7, 32'd0, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    hold_until_accepted("dep", st);
`ifdef ID_EX_FORWARDING_EN
    chk("dep_stalls", st, 0);
`else
    chk("dep_stalls", st, 2);
`endif
    nop();
    #1;
    chk("dep_a", alu_a, 32'h1006);
    cycle(); cycle(); cycle();

    // flush together with a load-use stall, then reset mid-stream
    set_id(1'b1, 5'd0, 5'd0, 5'd4, 32'h20, 1'b1, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle();
    set_id(1'b1, 5'd4, 5'd4, 5'd11, 32'd0, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    chk("flush_stall", stall, 1'b1);
    cycle();
    flush = 1'b0;
    chk("flush_bubble", ex_valid, 1'b0);
    set_id(1'b1, 5'd1, 5'd2, 5'd10, 32'd0, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("pre_rst_valid", ex_valid, 1'b1);
    set_id(1'b1, 5'd2, 5'd1, 5'd12, 32'h3, 1'b1, ALU_SLT, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    set_id(1'b1, 5'd1, 5'd2, 5'd13, 32'd0, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_valid", ex_valid, 1'b0);
    chk("rst_a", alu_a, 32'd0);
    chk("rst_rd", ex_rd, 5'd0);
    chk("rst_stall", stall, 1'b0);
    cycle();
    nop();
    cycle(); cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
